// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Streams a program into instruction memory over a valid/ready word stream
//   while holding the core in reset. Once the last word is written it keeps
//   core_reset high for RESET_HOLD more cycles and then releases the core,
//   which runs from PC 0. A load_start seen in RUN reloads a new program.
//
// Ports
//   clk, reset    rising-edge clock, synchronous active-high reset
//   load_start    one-cycle pulse starting a load of load_len words
//   load_len      program length in words, clamped to 2**ADDR_WIDTH
//   s_valid       stream word valid
//   s_data        stream word, word 0 first
//   s_ready       combinational: high in LOAD only
//   imem_we       imem write strobe, one cycle per accepted word
//   imem_addr     imem byte address (word index << 2)
//   imem_wdata    imem write data
//   core_reset    active-high reset driven to the core
//   busy          high in LOAD or HOLD
//   load_done     high in RUN
//   word_count    words written during the current load
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int RESET_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  s_valid,
    input  logic [31:0]           s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] len;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [ADDR_WIDTH:0] start_len;
    logic                handshake;

    assign s_ready   = (state == LOAD);
    assign handshake = s_valid & s_ready;
    assign start_len = (load_len > MAX_LEN) ? MAX_LEN : load_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (load_start) begin
                        len        <= start_len;
                        word_count <= '0;
                        hold_cnt   <= '0;
                        core_reset <= 1'b1;
                        load_done  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= (start_len == '0) ? HOLD : LOAD;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= {{(30 - ADDR_WIDTH){1'b0}}, word_count[ADDR_WIDTH-1:0], 2'b00};
                        imem_wdata <= s_data;
                        word_count <= word_count + 1'b1;
                        // Leaving LOAD on the last word is what saturates word_count at len.
                        if (word_count == len - 1'b1)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        load_done  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: randomized and directed loads checked
// against a word-level reference model (expected length, write sequence and
// reset release timing derived from the load rules).
module tb_imem_boot_loader;

    localparam int AW   = 8;
    localparam int HOLD = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          busy;
    logic          load_done;
    logic [AW:0]   word_count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] data_tbl [3] = '{32'h00500093, 32'h00300113, 32'h002081B3};
    bit          use_tbl = 1'b0;

    imem_boot_loader #(.ADDR_WIDTH(AW), .RESET_HOLD(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .load_done  (load_done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full load: pulse load_start, stream words, then check the reset release.
    // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid.
    task automatic run_load(input int unsigned req_len, input int mode, input string tag);
        int unsigned mlen;
        int unsigned mcount = 0;
        int unsigned cyc = 0;
        bit          hs;
        logic [31:0] d;
        logic [AW:0] len_bits;
        mlen = (req_len > DEPTH) ? DEPTH : req_len;
        len_bits = req_len[AW:0];
        load_start = 1'b1; load_len = len_bits; s_valid = 1'b0;
        step();
        load_start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0) begin
            n_bad++; $display("FAIL %s start_flags: got busy=%b crst=%b done=%b want 1 1 0", tag, busy, core_reset, load_done);
        end
        n_cmp++; if (word_count !== '0) begin
            n_bad++; $display("FAIL %s start_count: got %0d want 0", tag, word_count);
        end
        while (mcount < mlen && cyc < 4 * mlen + 20) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = cyc[0];
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            d = use_tbl ? data_tbl[mcount] : $urandom();
            s_data = d;
            n_cmp++; if (s_ready !== 1'b1) begin
                n_bad++; $display("FAIL %s s_ready_load: got %b want 1", tag, s_ready);
            end
            hs = s_valid;
            step();
            cyc++;
            n_cmp++; if (imem_we !== hs) begin
                n_bad++; $display("FAIL %s imem_we: got %b want %b (word %0d)", tag, imem_we, hs, mcount);
            end
            if (hs) begin
                n_cmp++; if (imem_addr !== mcount * 4 || imem_wdata !== d) begin
                    n_bad++; $display("FAIL %s write: got addr=%h data=%h want addr=%h data=%h", tag, imem_addr, imem_wdata, mcount * 4, d);
                end
                mcount++;
            end
            n_cmp++; if (word_count !== mcount[AW:0]) begin
                n_bad++; $display("FAIL %s word_count: got %0d want %0d", tag, word_count, mcount);
            end
        end
        if (mcount < mlen) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: got %0d words want %0d", tag, mcount, mlen);
        end
        // Core stays in reset for HOLD cycles after the last write is visible.
        for (int k = 0; k < HOLD; k++) begin
            n_cmp++; if (core_reset !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL %s hold_%0d: got crst=%b rdy=%b busy=%b want 1 0 1", tag, k, core_reset, s_ready, busy);
            end
            s_valid = 1'($urandom_range(0, 1));
            step();
            n_cmp++; if (imem_we !== 1'b0) begin
                n_bad++; $display("FAIL %s hold_we_%0d: got %b want 0", tag, k, imem_we);
            end
        end
        s_valid = 1'b0;
        n_cmp++; if (core_reset !== 1'b0 || load_done !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL %s run_flags: got crst=%b done=%b busy=%b want 0 1 0", tag, core_reset, load_done, busy);
        end
        n_cmp++; if (word_count !== mlen[AW:0]) begin
            n_bad++; $display("FAIL %s final_count: got %0d want %0d", tag, word_count, mlen);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_start = 1'b0; load_len = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) step();
        n_cmp++; if (core_reset !== 1'b1 || s_ready !== 1'b0 || imem_we !== 1'b0 || load_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got crst=%b rdy=%b we=%b done=%b busy=%b want 1 0 0 0 0",
                              core_reset, s_ready, imem_we, load_done, busy);
        end
        n_cmp++; if (imem_addr !== '0 || imem_wdata !== '0 || word_count !== '0) begin
            n_bad++; $display("FAIL reset_regs: got addr=%h data=%h cnt=%0d want 0 0 0", imem_addr, imem_wdata, word_count);
        end
        reset = 1'b0;
        // Stream traffic in IDLE must not write.
        s_valid = 1'b1; s_data = 32'hDEADBEEF;
        repeat (3) begin
            step();
            n_cmp++; if (imem_we !== 1'b0 || s_ready !== 1'b0 || core_reset !== 1'b1) begin
                n_bad++; $display("FAIL idle_valid: got we=%b rdy=%b crst=%b want 0 0 1", imem_we, s_ready, core_reset);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        use_tbl = 1'b1;
        run_load(3, 0, "b2b");
        use_tbl = 1'b0;
    endtask

    task automatic test_toggle_valid();
        use_tbl = 1'b1;
        run_load(3, 1, "toggle");
        use_tbl = 1'b0;
    endtask

    task automatic test_run_valid_ignored();
        logic [AW:0] cnt_before;
        cnt_before = word_count;
        s_valid = 1'b1; s_data = $urandom();
        repeat (4) begin
            step();
            n_cmp++; if (imem_we !== 1'b0 || word_count !== cnt_before || core_reset !== 1'b0) begin
                n_bad++; $display("FAIL run_valid: got we=%b cnt=%0d crst=%b want 0 %0d 0", imem_we, word_count, core_reset, cnt_before);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_empty();
        run_load(0, 0, "empty");
    endtask

    task automatic test_overflow();
        run_load(300, 0, "ovf");
        n_cmp++; if (imem_addr !== 32'h3FC) begin
            n_bad++; $display("FAIL ovf_last_addr: got %h want 000003fc", imem_addr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            run_load($urandom_range(1, 24), 2, "rand");
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1; load_len = 9'd3; s_valid = 1'b0;
        step();
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 32'h11111111;
        step();
        s_valid = 1'b0;
        n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h11111111) begin
            n_bad++; $display("FAIL mid_first: got we=%b addr=%h data=%h want 1 0 11111111", imem_we, imem_addr, imem_wdata);
        end
        // A second load_start while loading must not restart the load.
        load_start = 1'b1; load_len = 9'd5;
        step();
        load_start = 1'b0;
        n_cmp++; if (word_count !== 9'd1 || s_ready !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_start_ignored: got cnt=%0d rdy=%b busy=%b want 1 1 1", word_count, s_ready, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (core_reset !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || word_count !== '0 || load_done !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: got crst=%b busy=%b rdy=%b cnt=%0d done=%b want 1 0 0 0 0",
                              core_reset, busy, s_ready, word_count, load_done);
        end
        run_load(2, 0, "reload");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_run_valid_ignored();
        test_toggle_valid();
        test_empty();
        test_overflow();
        test_random();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
